// File: rtl/uart_frame_parse.sv
// uart_frame_parse
//
// Receive-side parser for the 14-byte vision-board target frame:
//   FF FF | 10 payload bytes (80-bit packed, MSB first) | 0D 0A
// Validates each frame and unpacks the two target centres and the two
// position differences into held output registers.
//
// Parameters:
//   TIMEOUT_CYCLES - maximum idle cycles allowed between bytes inside a frame
//   CHECK_RSVD     - when 1, any nonzero reserved payload bit rejects the frame
//
// Ports:
//   clk         - clock
//   reset       - asynchronous active-low reset
//   rx_data     - received byte, qualified by rx_valid
//   rx_valid    - one-cycle strobe per received byte
//   x1, x2      - target centre X coordinates (11 bit)
//   y1, y2      - target centre Y coordinates (10 bit)
//   diff1/diff2 - target position differences (12 bit)
//   frame_valid - one-cycle pulse when a good frame is committed
//   frame_err   - one-cycle pulse when a frame is rejected
//   err_code    - last rejection reason: 1 trailer, 2 reserved bit, 3 timeout
//   frame_cnt   - good frame count (wraps)
//   err_cnt     - rejected frame count (wraps)

module uart_frame_parse #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
  parameter bit          CHECK_RSVD     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [10:0] x1,
  output logic [10:0] x2,
  output logic [9:0]  y1,
  output logic [9:0]  y2,
  output logic [11:0] diff1,
  output logic [11:0] diff2,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [2:0] StHunt = 3'd0;
  localparam logic [2:0] StHdr2 = 3'd1;
  localparam logic [2:0] StPay  = 3'd2;
  localparam logic [2:0] StTr1  = 3'd3;
  localparam logic [2:0] StTr2  = 3'd4;

  localparam logic [1:0] ErrTrailer = 2'd1;
  localparam logic [1:0] ErrRsvd    = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [79:0] shadow_q, shadow_d;
  logic [23:0] idle_q, idle_d;

  logic        accept;
  logic        reject;
  logic [1:0]  rej_code;
  logic        rsvd_set;

  assign rsvd_set = shadow_q[79] | shadow_q[67] | (|shadow_q[55:54]) | (|shadow_q[43:42]) |
                    (|shadow_q[31:28]) | (|shadow_q[15:12]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    idle_d   = idle_q;
    accept   = 1'b0;
    reject   = 1'b0;
    rej_code = 2'd0;

    if (rx_valid) begin
      // A byte always wins over a coincident timeout.
      idle_d = '0;
      case (state_q)
        StHunt: begin
          if (rx_data == 8'hFF) state_d = StHdr2;
        end
        StHdr2: begin
          if (rx_data == 8'hFF) begin
            state_d = StPay;
            idx_d   = 4'd0;
          end else begin
            state_d = StHunt;
          end
        end
        StPay: begin
          // Payload byte 0 can never be FF (bit 79 clear), so FF there is an extra header byte.
          if (!(idx_q == 4'd0 && rx_data == 8'hFF)) begin
            // Shifting in MSB first lands byte k at [79-8k : 72-8k] after ten bytes.
            shadow_d = {shadow_q[71:0], rx_data};
            idx_d    = idx_q + 4'd1;
            if (idx_q == 4'd9) state_d = StTr1;
          end
        end
        StTr1: begin
          if (rx_data == 8'h0D) begin
            state_d = StTr2;
          end else begin
            reject   = 1'b1;
            rej_code = ErrTrailer;
            state_d  = StHunt;
          end
        end
        StTr2: begin
          state_d = StHunt;
          if (rx_data != 8'h0A) begin
            reject   = 1'b1;
            rej_code = ErrTrailer;
          end else if (CHECK_RSVD && rsvd_set) begin
            reject   = 1'b1;
            rej_code = ErrRsvd;
          end else begin
            accept = 1'b1;
          end
        end
        default: state_d = StHunt;
      endcase
    end else if (state_q != StHunt) begin
      if (idle_q == TIMEOUT_CYCLES) begin
        reject   = 1'b1;
        rej_code = ErrTimeout;
        state_d  = StHunt;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + 24'd1;
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StHunt;
      idx_q    <= '0;
      shadow_q <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      idle_q   <= idle_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1          <= '0;
      x2          <= '0;
      y1          <= '0;
      y2          <= '0;
      diff1       <= '0;
      diff2       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= accept;
      frame_err   <= reject;
      if (accept) begin
        x1        <= shadow_q[78:68];
        x2        <= shadow_q[66:56];
        y1        <= shadow_q[53:44];
        y2        <= shadow_q[41:32];
        diff1     <= shadow_q[27:16];
        diff2     <= shadow_q[11:0];
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (reject) begin
        err_code <= rej_code;
        err_cnt  <= err_cnt + 16'd1;
      end
    end
  end

endmodule
